// File: rtl/dac_spi_writer.sv
// Serial DAC writer: shifts a 16-bit sample MSB-first over SPI mode 0 with active-low CS.
// One-deep request buffer with busy/done/overrun status for the control FSM.
// Optional LDAC load pulse after each frame is enabled by defining DAC_SPI_WRITER_LDAC_EN.
module dac_spi_writer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned CS_GAP     = 2,
  parameter int unsigned LDAC_WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        latch_i,
  input  logic [15:0] data_i,
  output logic        cs_dac_o,
  output logic        clk_dac_o,
  output logic        sdo_dac_o,
  output logic        ldac_dac_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);

  // The sum bounds every individual count, so one shared counter width fits all phases.
  localparam int unsigned CntMax = CLK_DIV + CS_SETUP + CS_HOLD + CS_GAP + LDAC_WIDTH;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
`ifdef DAC_SPI_WRITER_LDAC_EN
    StLdac,
`endif
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     shift_q, shift_d;
  logic            pend_q, pend_d;
  logic [15:0]     pend_data_q, pend_data_d;
  logic            cs_q, cs_d;
  logic            sck_q, sck_d;
  logic            sdo_q, sdo_d;
  logic            ldac_q, ldac_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            l1_q, l2_q;
  logic            req;

  assign req = l1_q & ~l2_q;

  // Synchronise LATCH and keep all FSM/output state; reset drops any frame in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      l1_q        <= 1'b0;
      l2_q        <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      sdo_q       <= 1'b0;
      ldac_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      l1_q        <= latch_i;
      l2_q        <= l1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      sdo_q       <= sdo_d;
      ldac_q      <= ldac_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  // Next-state logic for request buffering and the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    cs_d        = cs_q;
    sck_d       = sck_q;
    sdo_d       = sdo_q;
    ldac_d      = ldac_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovr_d       = 1'b0;

    // Requests outside IDLE (including the GAP exit edge) are buffered; newest wins.
    if (req && (state_q != StIdle)) begin
      pend_d      = 1'b1;
      pend_data_d = data_i;
      ovr_d       = pend_q;
    end

    unique case (state_q)
      StIdle: begin
        if (req || pend_q) begin
          if (pend_q) begin
            // Older buffered sample goes first; a coincident new request stays queued.
            shift_d = pend_data_q;
            pend_d  = req;
            if (req) pend_data_d = data_i;
          end else begin
            shift_d = data_i;
          end
          sdo_d   = shift_d[15];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        // SCK toggles after each full CLK_DIV interval, so SHIFT spans 32 half-periods.
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            if (bit_q == 4'd15) begin
              sdo_d   = 1'b0;
              state_d = StHold;
            end else begin
              sdo_d   = shift_q[14];
              shift_d = {shift_q[14:0], 1'b0};
              bit_d   = bit_q + 4'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == CntW'(CS_HOLD - 1)) begin
          cs_d  = 1'b1;
          cnt_d = '0;
`ifdef DAC_SPI_WRITER_LDAC_EN
          state_d = StLdac;
`else
          state_d = StGap;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef DAC_SPI_WRITER_LDAC_EN
      StLdac: begin
        // First cycle keeps LDAC high after CS rises, then LDAC_WIDTH cycles low.
        if (cnt_q == '0) ldac_d = 1'b0;
        if (cnt_q == CntW'(LDAC_WIDTH)) begin
          ldac_d  = 1'b1;
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StGap: begin
        if (cnt_q == CntW'(CS_GAP - 1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cs_dac_o   = cs_q;
  assign clk_dac_o  = sck_q;
  assign sdo_dac_o  = sdo_q;
  assign ldac_dac_o = ldac_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Self-checking bench for dac_spi_writer (default parameters).
module tb_dac_spi_writer;

`ifdef DAC_SPI_WRITER_LDAC_EN
  localparam int ExpDone = 7;  // CS rise -> DONE: 1 + LDAC_WIDTH + CS_GAP
`else
  localparam int ExpDone = 2;  // CS rise -> DONE: CS_GAP
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        latch_i = 1'b0;
  logic [15:0] data_i = 16'h0000;
  logic        cs_dac_o, clk_dac_o, sdo_dac_o, ldac_dac_o, busy_o, done_o, overrun_o;

  dac_spi_writer dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .latch_i    (latch_i),
    .data_i     (data_i),
    .cs_dac_o   (cs_dac_o),
    .clk_dac_o  (clk_dac_o),
    .sdo_dac_o  (sdo_dac_o),
    .ldac_dac_o (ldac_dac_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Monitor: sampled on the falling clock edge, stamps events with a cycle index.
  int          cyc = 0, falls = 0, dones = 0, ovrs = 0, idle_act = 0, ldac_lows = 0;
  int          cs_run = 0, last_low = 0, rise_cyc = 0, fall_cyc = 0, done_cyc = 0;
  int          fr_rises = 0, fr_badint = 0, last_rise_cyc = 0;
  int          ldac_fall_cyc = 0, ldac_rise_cyc = 0;
  logic [15:0] fr_bits = 16'h0000;
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_ldac = 1'b1;

  always @(negedge clk_i) begin
    cyc       <= cyc + 1;
    prev_cs   <= cs_dac_o;
    prev_sck  <= clk_dac_o;
    prev_ldac <= ldac_dac_o;
    if (!cs_dac_o && prev_cs) begin
      falls     <= falls + 1;
      fall_cyc  <= cyc;
      cs_run    <= 1;
      fr_rises  <= 0;
      fr_badint <= 0;
    end else if (!cs_dac_o) begin
      cs_run <= cs_run + 1;
    end
    if (cs_dac_o && !prev_cs) begin
      last_low <= cs_run;
      rise_cyc <= cyc;
    end
    if (clk_dac_o && !prev_sck) begin
      fr_rises      <= fr_rises + 1;
      fr_bits       <= {fr_bits[14:0], sdo_dac_o};
      last_rise_cyc <= cyc;
      if (fr_rises != 0 && (cyc - last_rise_cyc) != 8) fr_badint <= fr_badint + 1;
    end
    if (cs_dac_o && (clk_dac_o || sdo_dac_o)) idle_act <= idle_act + 1;
    if (!ldac_dac_o) ldac_lows <= ldac_lows + 1;
    if (!ldac_dac_o && prev_ldac) ldac_fall_cyc <= cyc;
    if (ldac_dac_o && !prev_ldac) ldac_rise_cyc <= cyc;
    if (done_o) begin
      dones    <= dones + 1;
      done_cyc <= cyc;
    end
    if (overrun_o) ovrs <= ovrs + 1;
  end

  typedef struct {
    logic [15:0] data;
    int          exp_low;
    int          exp_rises;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Holds LATCH and DATA across the request edge, then scrambles DATA.
  task automatic send(input logic [15:0] d, output int c0);
    @(negedge clk_i); #1;
    latch_i = 1'b1;
    data_i  = d;
    c0      = cyc;
    @(negedge clk_i); #1;
    @(negedge clk_i); #1;
    latch_i = 1'b0;
    data_i  = ~d;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (dones < target && n < budget) begin
      @(negedge clk_i); #1;
      n++;
    end
    check("done_seen", 32'(dones >= target), 32'd1);
  endtask

  initial begin
    int c0, d0, o0, f0, done1, n;

    vecs[0] = '{16'hA5C3, 132, 16, ExpDone};
    vecs[1] = '{16'hFFFF, 132, 16, ExpDone};
    vecs[2] = '{16'h0000, 132, 16, ExpDone};
    vecs[3] = '{16'h8001, 132, 16, ExpDone};
    vecs[4] = '{16'h7E18, 132, 16, ExpDone};

    // Reset state
    #2 rst_ni = 1'b0;
    #1;
    check("rst_cs", 32'(cs_dac_o), 32'd1);
    check("rst_sck", 32'(clk_dac_o), 32'd0);
    check("rst_sdo", 32'(sdo_dac_o), 32'd0);
    check("rst_ldac", 32'(ldac_dac_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    repeat (3) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (50) @(negedge clk_i);
    #1;
    check("idle_falls", 32'(falls), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_cs", 32'(cs_dac_o), 32'd1);
    check("idle_sck", 32'(clk_dac_o), 32'd0);

    // Single frames from the table
    for (int i = 0; i < 5; i++) begin
      d0 = dones;
      o0 = ovrs;
      send(vecs[i].data, c0);
      wait_done(d0 + 1, 400);
      check("req_to_cs", 32'(fall_cyc - c0), 32'd1);
      check("frame_bits", 32'(fr_bits), 32'(vecs[i].data));
      check("cs_low_len", 32'(last_low), 32'(vecs[i].exp_low));
      check("sck_rises", 32'(fr_rises), 32'(vecs[i].exp_rises));
      check("sck_period", 32'(fr_badint), 32'd0);
      check("done_delay", 32'(done_cyc - rise_cyc), 32'(vecs[i].exp_done));
      check("no_overrun", 32'(ovrs - o0), 32'd0);
`ifdef DAC_SPI_WRITER_LDAC_EN
      check("ldac_start", 32'(ldac_fall_cyc - rise_cyc), 32'd1);
      check("ldac_width", 32'(ldac_rise_cyc - ldac_fall_cyc), 32'd4);
      check("ldac_to_done", 32'(done_cyc - ldac_fall_cyc), 32'd6);
`endif
      repeat (5) @(negedge clk_i);
    end

    // Request mid-frame is queued and follows right after DONE
    d0 = dones;
    o0 = ovrs;
    send(16'hFFFF, c0);
    repeat (40) @(negedge clk_i);
    send(16'h1234, c0);
    wait_done(d0 + 1, 400);
    check("q1_bits", 32'(fr_bits), 32'h0000FFFF);
    done1 = done_cyc;
    wait_done(d0 + 2, 400);
    check("q2_bits", 32'(fr_bits), 32'h00001234);
    check("q2_start", 32'(fall_cyc - done1), 32'd1);
    check("q_no_ovr", 32'(ovrs - o0), 32'd0);

    // Three requests in one frame: last pending wins, one overrun
    d0 = dones;
    o0 = ovrs;
    send(16'h0001, c0);
    repeat (10) @(negedge clk_i);
    send(16'h0002, c0);
    send(16'h0003, c0);
    wait_done(d0 + 1, 400);
    check("ov1_bits", 32'(fr_bits), 32'h00000001);
    wait_done(d0 + 2, 400);
    check("ov2_bits", 32'(fr_bits), 32'h00000003);
    check("ov_count", 32'(ovrs - o0), 32'd1);
    f0 = falls;
    repeat (200) @(negedge clk_i);
    check("ov_no_third", 32'(falls - f0), 32'd0);

    // Request landing on the GAP exit edge is kept as pending
    d0 = dones;
    o0 = ovrs;
    send(16'h0F0F, c0);
    while (cyc < c0 + 134) begin
      @(negedge clk_i); #1;
    end
    latch_i = 1'b1;
    data_i  = 16'h5A5A;
    @(negedge clk_i); #1;
    @(negedge clk_i); #1;
    latch_i = 1'b0;
    data_i  = 16'hFFFF;
    wait_done(d0 + 1, 400);
    check("gx1_bits", 32'(fr_bits), 32'h00000F0F);
    done1 = done_cyc;
    wait_done(d0 + 2, 400);
    check("gx2_bits", 32'(fr_bits), 32'h00005A5A);
    check("gx2_start", 32'(fall_cyc - done1), 32'd1);
    check("gx_no_ovr", 32'(ovrs - o0), 32'd0);
    repeat (5) @(negedge clk_i);

    // Asynchronous reset on the 8th SCK rise aborts the frame for good
    f0 = falls;
    send(16'hC3C3, c0);
    n = 0;
    while (!(falls > f0 && fr_rises >= 8) && n < 300) begin
      @(negedge clk_i); #1;
      n++;
    end
    check("rst_reach8", 32'(fr_rises), 32'd8);
    #1 rst_ni = 1'b0;
    #1;
    check("arst_cs", 32'(cs_dac_o), 32'd1);
    check("arst_sck", 32'(clk_dac_o), 32'd0);
    check("arst_sdo", 32'(sdo_dac_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    f0 = falls;
    repeat (300) @(negedge clk_i);
    #1;
    check("arst_no_resume", 32'(falls - f0), 32'd0);
    check("arst_idle_busy", 32'(busy_o), 32'd0);

    check("idle_activity", 32'(idle_act), 32'd0);
`ifndef DAC_SPI_WRITER_LDAC_EN
    check("ldac_const", 32'(ldac_lows), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
